// File: rtl/axi_lite_reg_slave.sv
// ============================================================================
// axi_lite_reg_slave
// ----------------------------------------------------------------------------
// AXI4-Lite slave register bank. It terminates the AXI-Lite bus and holds
// NUM_REGS read/write control registers. The contents of every register are
// exported to the core logic on reg_out.
//
// Write path: AW and W are accepted independently, in either order or on the
// same edge. Each channel is parked in a holding register until its partner
// arrives. The write commits on the edge where both halves are present. One
// B response is then issued, and both channels stay closed until that
// response has been taken by the master.
//
// Read path: an accepted AR is answered on the same edge. RDATA/RRESP are
// registered from the pre-edge register contents. Only one read can be
// outstanding at a time.
//
// Addresses at or beyond NUM_REGS*4 get SLVERR. Such a write leaves the bank
// untouched, and such a read returns zero.
//
// Parameters
//   ADDR_WIDTH : width of AWADDR / ARADDR
//   DATA_WIDTH : data width, 32 or 64
//   NUM_REGS   : number of registers, power of two, >= 2
//
// Ports
//   ACLK, ARESETn                  : clock, asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY         : write address channel
//   WDATA/WSTRB/WVALID/WREADY      : write data channel
//   BRESP/BVALID/BREADY            : write response channel
//   ARADDR/ARVALID/ARREADY         : read address channel
//   RDATA/RRESP/RVALID/RREADY      : read data channel
//   reg_out                        : register i at [i*DATA_WIDTH +: DATA_WIDTH]
// ============================================================================
module axi_lite_reg_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,

    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,

    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,

    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,

    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,

    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,

    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = $clog2(NUM_REGS);

    // First byte address past the register bank
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                     rst_done;

    logic                     aw_held;
    logic [ADDR_WIDTH-1:0]    aw_addr_q;
    logic                     w_held;
    logic [DATA_WIDTH-1:0]    w_data_q;
    logic [STRB_WIDTH-1:0]    w_strb_q;

    logic                     bvalid_q;
    logic [1:0]               bresp_q;

    logic                     rvalid_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic [1:0]               rresp_q;

    logic [DATA_WIDTH-1:0]    regs [NUM_REGS];

    // ------------------------------------------------------------------
    // Handshakes and write-merge signals
    // ------------------------------------------------------------------
    logic                     aw_ready;
    logic                     w_ready;
    logic                     ar_ready;
    logic                     aw_hs;
    logic                     w_hs;
    logic                     ar_hs;
    logic                     commit;

    logic [ADDR_WIDTH-1:0]    wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic [STRB_WIDTH-1:0]    wr_strb;
    logic                     wr_in_range;
    logic [IDX_WIDTH-1:0]     wr_idx;

    logic                     rd_in_range;
    logic [IDX_WIDTH-1:0]     rd_idx;
    logic [DATA_WIDTH-1:0]    rd_word;

    // The readies depend only on internal state, never on VALID. This keeps
    // the slave free of any VALID-before-READY dependency.
    assign aw_ready = rst_done & ~aw_held & ~bvalid_q;
    assign w_ready  = rst_done & ~w_held  & ~bvalid_q;
    assign ar_ready = rst_done & ~rvalid_q;

    assign aw_hs = AWVALID & aw_ready;
    assign w_hs  = WVALID  & w_ready;
    assign ar_hs = ARVALID & ar_ready;

    // A commit needs both halves. Each half may come from its holding
    // register or from a handshake on this same edge.
    assign commit = (aw_held | aw_hs) & (w_held | w_hs);

    // While a channel is held its READY is low, so no new handshake can
    // collide with the held copy. The mux picks whichever source exists.
    always_comb begin
        wr_addr = aw_held ? aw_addr_q : AWADDR;
        wr_data = w_held  ? w_data_q  : WDATA;
        wr_strb = w_held  ? w_strb_q  : WSTRB;
    end

    assign wr_in_range = (wr_addr < ADDR_LIMIT);
    assign wr_idx      = wr_addr[IDX_WIDTH+1:2];

    assign rd_in_range = (ARADDR < ADDR_LIMIT);
    assign rd_idx      = ARADDR[IDX_WIDTH+1:2];
    assign rd_word     = rd_in_range ? regs[rd_idx] : '0;

    // ------------------------------------------------------------------
    // Reset-release flag: holds every READY low until the first clock edge
    // after ARESETn deasserts.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // AW / W holding registers. Once the write commits, both flags clear,
    // including any flag that was only about to be set on that edge.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_held   <= 1'b0;
            aw_addr_q <= '0;
            w_held    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= AWADDR;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write response. BRESP is captured at commit and then frozen until the
    // master accepts it.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && BREADY) begin
            bvalid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register bank with per-byte-lane update. Lanes whose strobe is clear
    // keep their value, so a zero strobe is a legal no-op write.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && wr_in_range) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read response. rd_word samples the bank before this edge's update.
    // A read colliding with a commit to the same register therefore
    // returns the old value.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
            rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign AWREADY = aw_ready;
    assign WREADY  = w_ready;
    assign ARREADY = ar_ready;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    // Flatten the bank for the core logic
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// ============================================================================
// tb_axi_lite_reg_slave
// ----------------------------------------------------------------------------
// Self-checking bench for axi_lite_reg_slave (32-bit data, 8 registers).
// A plain array of words models the register bank. Directed scenarios and
// randomized write/read traffic are compared against it.
// ============================================================================
module tb_axi_lite_reg_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic [AW-1:0]     AWADDR = '0;
    logic              AWVALID = 1'b0;
    logic              AWREADY;
    logic [DW-1:0]     WDATA = '0;
    logic [DW/8-1:0]   WSTRB = '0;
    logic              WVALID = 1'b0;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY = 1'b0;
    logic [AW-1:0]     ARADDR = '0;
    logic              ARVALID = 1'b0;
    logic              ARREADY;
    logic [DW-1:0]     RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY = 1'b0;
    logic [NR*DW-1:0]  reg_out;

    int checks = 0;
    int errors = 0;

    // Reference model of the register bank
    logic [DW-1:0] model [NR];

    axi_lite_reg_slave #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_REGS  (NR)
    ) dut (
        .ACLK   (ACLK),
        .ARESETn(ARESETn),
        .AWADDR (AWADDR),
        .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .WDATA  (WDATA),
        .WSTRB  (WSTRB),
        .WVALID (WVALID),
        .WREADY (WREADY),
        .BRESP  (BRESP),
        .BVALID (BVALID),
        .BREADY (BREADY),
        .ARADDR (ARADDR),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RDATA  (RDATA),
        .RRESP  (RRESP),
        .RVALID (RVALID),
        .RREADY (RREADY),
        .reg_out(reg_out)
    );

    always #5 ACLK = ~ACLK;

    // Hard stop in case some wait escapes its own bound
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // ------------------------------------------------------------------
    // Model helpers, written directly from the bank's rules
    // ------------------------------------------------------------------
    function automatic bit in_range(input logic [AW-1:0] addr);
        return addr < NR * 4;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [AW-1:0] addr);
        return in_range(addr) ? 2'b00 : 2'b10;
    endfunction

    function automatic void model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                        input logic [DW/8-1:0] strb);
        int idx;
        if (!in_range(addr)) return;
        idx = int'(addr) / 4;
        for (int b = 0; b < DW/8; b++) begin
            if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        end
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr);
        return in_range(addr) ? model[int'(addr) / 4] : '0;
    endfunction

    function automatic logic [NR*DW-1:0] model_vec();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Bus tasks. They start and end 1 time unit after a rising edge.
    // Ready/valid are sampled on the falling edge. A handshake seen there
    // completes on the following rising edge.
    // ------------------------------------------------------------------
    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [DW/8-1:0] strb, input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output bit lat_ok, output bit done);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc;
        aw_done = 0; w_done = 0; lat_ok = 0; done = 0; resp = 2'b11; cyc = 0;
        AWADDR = addr; WDATA = data; WSTRB = strb; BREADY = 1'b1;
        while (!(aw_done && w_done) && cyc < 100) begin
            AWVALID = !aw_done && (cyc >= aw_dly);
            WVALID  = !w_done && (cyc >= w_dly);
            @(negedge ACLK);
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
            cyc++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        if (aw_done && w_done) begin
            lat_ok = BVALID;
            resp   = BRESP;
            @(posedge ACLK); #1;
            done = !BVALID;
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                            output logic [1:0] resp, output bit got);
        bit fire;
        int cyc;
        fire = 0; got = 0; cyc = 0; data = '0; resp = 2'b11;
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
        while (!fire && cyc < 100) begin
            @(negedge ACLK);
            fire = ARREADY;
            @(posedge ACLK); #1;
            cyc++;
        end
        ARVALID = 1'b0;
        if (fire) begin
            got  = RVALID;
            data = RDATA;
            resp = RRESP;
            @(posedge ACLK); #1;
            got = got && !RVALID;
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        ARESETn = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (3) @(posedge ACLK);
        #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b_%b_%b_%b_%b_%b_%b_%h expected all zero",
                     AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA);
        end
        checks++;
        if (reg_out !== model_vec()) begin
            errors++;
            $display("[TB] FAIL reset_regs: got %h expected %h", reg_out, model_vec());
        end
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        checks++;
        if (AWREADY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready_before_edge: got %b expected 0", AWREADY);
        end
        @(posedge ACLK); #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL reset_ready_after_edge: got %b expected 111", {AWREADY, WREADY, ARREADY});
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp;
        logic [DW-1:0] rd;
        bit lat_ok, done, got;
        axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, resp, lat_ok, done);
        model_write(32'h4, 32'hDEADBEEF, 4'hF);
        checks++;
        if (!lat_ok || !done || resp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL basic_bresp: got lat=%0d done=%0d resp=%b expected 1 1 00", lat_ok, done, resp);
        end
        checks++;
        if (reg_out[63:32] !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL basic_reg_out: got %h expected deadbeef", reg_out[63:32]);
        end
        axi_read(32'h4, rd, resp, got);
        checks++;
        if (!got || rd !== 32'hDEADBEEF || resp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL basic_read: got got=%0d data=%h resp=%b expected 1 deadbeef 00", got, rd, resp);
        end
    endtask

    task automatic test_w_before_aw();
        bit fire;
        logic [DW-1:0] old2;
        old2 = model[2];
        BREADY = 1'b0;
        WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK);
        fire = WREADY;
        @(posedge ACLK); #1;
        WVALID = 1'b0;
        checks++;
        if (!fire || WREADY !== 1'b0 || AWREADY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wfirst_w_held: got fire=%0d wready=%b awready=%b expected 1 0 1", fire, WREADY, AWREADY);
        end
        repeat (2) begin
            @(posedge ACLK); #1;
        end
        checks++;
        if (BVALID !== 1'b0 || reg_out[95:64] !== old2) begin
            errors++;
            $display("[TB] FAIL wfirst_no_commit: got bvalid=%b reg2=%h expected 0 %h", BVALID, reg_out[95:64], old2);
        end
        AWADDR = 32'h8; AWVALID = 1'b1;
        @(negedge ACLK);
        fire = AWREADY;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        model_write(32'h8, 32'h12345678, 4'hF);
        checks++;
        if (!fire || BVALID !== 1'b1 || BRESP !== 2'b00 || reg_out[95:64] !== model[2]) begin
            errors++;
            $display("[TB] FAIL wfirst_commit: got fire=%0d bvalid=%b bresp=%b reg2=%h expected 1 1 00 %h",
                     fire, BVALID, BRESP, reg_out[95:64], model[2]);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) begin
                errors++;
                $display("[TB] FAIL wfirst_stall_%0d: got bvalid/bresp/awready/wready=%b expected 10000",
                         c, {BVALID, BRESP, AWREADY, WREADY});
            end
            @(posedge ACLK); #1;
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        checks++;
        if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL wfirst_release: got bvalid/awready/wready=%b expected 011", {BVALID, AWREADY, WREADY});
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp;
        bit lat_ok, done;
        axi_write(32'h0, 32'hFFFFFFFF, 4'hF, 0, 1, resp, lat_ok, done);
        model_write(32'h0, 32'hFFFFFFFF, 4'hF);
        axi_write(32'h0, 32'h000000AA, 4'b0001, 1, 0, resp, lat_ok, done);
        model_write(32'h0, 32'h000000AA, 4'b0001);
        checks++;
        if (reg_out[31:0] !== 32'hFFFFFFAA || resp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL strobe_lane0: got %h resp=%b expected ffffffaa 00", reg_out[31:0], resp);
        end
        axi_write(32'h0, 32'h12345678, 4'b0000, 0, 0, resp, lat_ok, done);
        checks++;
        if (reg_out !== model_vec() || resp !== 2'b00 || !done) begin
            errors++;
            $display("[TB] FAIL strobe_zero: got reg0=%h resp=%b expected %h 00", reg_out[31:0], resp, model[0]);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp;
        logic [DW-1:0] rd;
        bit lat_ok, done, got;
        axi_write(32'h20, 32'hCAFEF00D, 4'hF, 0, 0, resp, lat_ok, done);
        checks++;
        if (resp !== 2'b10 || !lat_ok || reg_out !== model_vec()) begin
            errors++;
            $display("[TB] FAIL oor_write: got resp=%b lat=%0d regs_match=%0d expected 10 1 1",
                     resp, lat_ok, reg_out === model_vec());
        end
        axi_read(32'h100, rd, resp, got);
        checks++;
        if (!got || resp !== 2'b10 || rd !== '0) begin
            errors++;
            $display("[TB] FAIL oor_read: got got=%0d resp=%b data=%h expected 1 10 0", got, resp, rd);
        end
    endtask

    task automatic test_same_edge_read();
        logic [1:0] resp;
        logic [DW-1:0] rd;
        bit lat_ok, done, got;
        logic [DW-1:0] pre;
        axi_write(32'h8, 32'h1, 4'hF, 0, 0, resp, lat_ok, done);
        model_write(32'h8, 32'h1, 4'hF);
        pre = model_read(32'h8);
        AWADDR = 32'h8; WDATA = 32'h2; WSTRB = 4'hF; BREADY = 1'b1;
        ARADDR = 32'h8; RREADY = 1'b0;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL same_edge_ready: got %b expected 111", {AWREADY, WREADY, ARREADY});
        end
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        model_write(32'h8, 32'h2, 4'hF);
        checks++;
        if (RVALID !== 1'b1 || RDATA !== pre || BVALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL same_edge_old_value: got rvalid=%b rdata=%h bvalid=%b expected 1 %h 1",
                     RVALID, RDATA, BVALID, pre);
        end
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        axi_read(32'h8, rd, resp, got);
        checks++;
        if (!got || rd !== model_read(32'h8)) begin
            errors++;
            $display("[TB] FAIL same_edge_new_value: got %h expected %h", rd, model_read(32'h8));
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] addr;
        logic [DW-1:0] data, rd;
        logic [DW/8-1:0] strb;
        logic [1:0] resp;
        bit lat_ok, done, got;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) addr = 32'(NR * 4) + 32'($urandom_range(0, 255));
            else addr = 32'($urandom_range(0, NR * 4 - 1));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp, lat_ok, done);
                model_write(addr, data, strb);
                checks++;
                if (!lat_ok || !done || resp !== exp_resp(addr) || reg_out !== model_vec()) begin
                    errors++;
                    $display("[TB] FAIL rand_write_%0d: addr=%h got lat=%0d done=%0d resp=%b reg_out=%h expected 1 1 %b %h",
                             n, addr, lat_ok, done, resp, reg_out, exp_resp(addr), model_vec());
                end
            end else begin
                axi_read(addr, rd, resp, got);
                checks++;
                if (!got || rd !== model_read(addr) || resp !== exp_resp(addr)) begin
                    errors++;
                    $display("[TB] FAIL rand_read_%0d: addr=%h got got=%0d data=%h resp=%b expected 1 %h %b",
                             n, addr, got, rd, resp, model_read(addr), exp_resp(addr));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp;
        bit lat_ok, done, fire;
        logic [DW-1:0] rd;
        bit got;
        axi_write(32'h4, 32'hA5A5A5A5, 4'hF, 0, 0, resp, lat_ok, done);
        model_write(32'h4, 32'hA5A5A5A5, 4'hF);
        AWADDR = 32'hC; AWVALID = 1'b1;
        @(negedge ACLK);
        fire = AWREADY;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        checks++;
        if (!fire || AWREADY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_aw_held: got fire=%0d awready=%b expected 1 0", fire, AWREADY);
        end
        #2;
        ARESETn = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA} !== '0 || reg_out !== model_vec()) begin
            errors++;
            $display("[TB] FAIL midrst_outputs: got ctl=%b reg_out=%h expected all zero",
                     {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, reg_out);
        end
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        checks++;
        if (AWREADY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_awready: got %b expected 1", AWREADY);
        end
        WDATA = 32'h77777777; WSTRB = 4'hF; WVALID = 1'b1;
        @(posedge ACLK); #1;
        WVALID = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (BVALID !== 1'b0 || reg_out !== model_vec()) begin
                errors++;
                $display("[TB] FAIL midrst_no_resp_%0d: got bvalid=%b expected 0", c, BVALID);
            end
            @(posedge ACLK); #1;
        end
        axi_read(32'h4, rd, resp, got);
        checks++;
        if (!got || rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midrst_reg_cleared: got %h expected 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_strobe();
        test_out_of_range();
        test_same_edge_read();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
AXI4-Lite slave register bank that terminates the AXI-Lite bus carried on our AXI-Lite interface. It is the downstream consumer of the master-side transactions.
- Holds NUM_REGS read/write control registers.
- Accepts the AW and W channels independently.
- Returns OKAY or SLVERR responses.
- Exports all register contents to the core logic.

Parameters:
ADDR_WIDTH, 32, width of AWADDR/ARADDR
DATA_WIDTH, 32, data width; restricted to 32 or 64
NUM_REGS, 8, number of registers; power of two, at least 2

Ports:
ACLK  input  1  clock
ARESETn  input  1  asynchronous active-low reset
AWADDR  input  ADDR_WIDTH  write address
AWVALID  input  1  write address valid
AWREADY  output  1  write address ready
WDATA  input  DATA_WIDTH  write data
WSTRB  input  DATA_WIDTH/8  byte-lane strobes
WVALID  input  1  write data valid
WREADY  output  1  write data ready
BRESP  output  2  write response
BVALID  output  1  write response valid
BREADY  input  1  write response ready
ARADDR  input  ADDR_WIDTH  read address
ARVALID  input  1  read address valid
ARREADY  output  1  read address ready
RDATA  output  DATA_WIDTH  read data
RRESP  output  2  read response
RVALID  output  1  read data valid
RREADY  input  1  read data ready
reg_out  output  NUM_REGS*DATA_WIDTH  register contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (ARESETn=0, async):
  - All outputs 0; all registers 0.
  - The aw_held/w_held flags and any pending B/R responses are discarded.
  - rst_done flop = 0; it sets at the first ACLK edge with ARESETn=1. All READYs are gated by rst_done.
- Address decode:
  - Word index = ADDR[log2(NUM_REGS)+1:2]; ADDR[1:0] ignored.
  - In range iff ADDR < NUM_REGS*4.
  - Otherwise the access gets SLVERR (2'b10). OKAY = 2'b00.
- Write channel:
  - AWREADY = rst_done & !aw_held & !BVALID.
  - WREADY = rst_done & !w_held & !BVALID.
  - An AW handshake latches the address and sets aw_held. A W handshake latches WDATA/WSTRB and sets w_held. AW and W may complete in either order or on the same edge.
  - Commit happens at the edge where both held flags (including the ones being set on that edge) are true:
    - In range: each byte lane with WSTRB=1 is updated; other lanes are unchanged.
    - Out of range: no register changes.
    - BVALID←1, BRESP←OKAY/SLVERR, held flags cleared.
  - Latency: BVALID is high in the cycle after the final handshake.
  - BVALID and BRESP hold stable until BREADY=1 is sampled. BVALID then clears on that edge, and the readies reassert the next cycle.
  - A write with WSTRB=0 gets OKAY and changes nothing.
- Read channel:
  - ARREADY = rst_done & !RVALID.
  - On an AR handshake, at the same edge: RVALID←1, RDATA←reg[index] (or 0 if out of range), RRESP←OKAY/SLVERR.
  - RDATA and RRESP hold stable until the RREADY handshake. RVALID clears on that edge.
  - One outstanding read at a time.
- Simultaneous events:
  - Read and write channels are fully independent.
  - An AR handshake on the same edge as a write commit to the same register returns the pre-write value.
- reg_out reflects the register state, updated on the commit edge.
- A reset asserted mid-transaction drops the transaction entirely. No response is issued after release.
- VALID-before-READY dependency: the slave never waits on VALID to assert READY, beyond the held/pending conditions above.

Test Plan:
- Write to 0x04, WDATA=0xDEADBEEF, WSTRB=4'hF, BREADY=1 -> BVALID the cycle after the handshake, BRESP=00, reg_out[63:32]=0xDEADBEEF. Read 0x04 -> RDATA=0xDEADBEEF, RRESP=00.
- W presented 3 cycles before AW (addr 0x08, data 0x12345678); BREADY held low 4 cycles -> WREADY low after the W handshake, no commit until AW, BVALID/BRESP stable for 4 cycles, AWREADY/WREADY low while BVALID=1.
- Reg 0 = 0xFFFFFFFF; write 0x00 with WDATA=0x000000AA, WSTRB=4'b0001 -> reg 0 = 0xFFFFFFAA.
- Write 0x20 and read 0x100 (NUM_REGS=8) -> BRESP=10 with no register changed; RRESP=10 with RDATA=0.
- Reg 2 = 0x1; AR to 0x08 on the same edge as the commit of 0x2 to 0x08 -> RDATA=0x1; a following read returns 0x2.
- AW accepted, then ARESETn pulsed low before W -> all outputs 0, no BVALID after release, all registers 0, AWREADY reasserts one cycle after release.
